// File: rtl/pwm_serial_driver.sv
// Serialises parallel PWM words onto a 74HC595-style chain (SER/SRCLK/RCLK).
// Optional: define PWM_SERIAL_SKIP_UNCHANGED_EN to drop words equal to the last one latched.
module pwm_serial_driver #(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             sr_clk,
  output logic             sr_latch,
  output logic             busy
);

  localparam int             BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0]  BIT_LAST = BW'(WIDTH - 1);
  localparam logic [7:0]     DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLK_LO,
    CLK_HI,
    LATCH
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [WIDTH-1:0] shifted;
  logic [BW-1:0]    bit_cnt;
  logic [BW-1:0]    bit_next;
  logic [7:0]       div_cnt;
  logic [7:0]       div_next;
  logic             ser_next;
  logic             div_done;
  logic             start;
  logic             repeat_word;

`ifdef PWM_SERIAL_SKIP_UNCHANGED_EN
  logic [WIDTH-1:0] last_word;
  logic [WIDTH-1:0] pend_word;
  logic             latch_enter;

  assign repeat_word = (data_in == last_word);
  assign latch_enter = (state == CLK_HI) && div_done && (bit_cnt == BIT_LAST);

  // pend_word keeps the original word since shreg is consumed while shifting
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_word <= '0;
      pend_word <= '0;
    end else begin
      if (start) begin
        pend_word <= data_in;
      end
      if (latch_enter) begin
        last_word <= pend_word;
      end
    end
  end
`else
  assign repeat_word = 1'b0;
`endif

  assign div_done   = (div_cnt == DIV_LAST);
  assign shifted    = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
  assign start      = (state == IDLE) && data_valid && !repeat_word;
  assign data_ready = ~busy;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ser_out only moves on CLK_HI->CLK_LO so each sr_clk rise gets CLK_DIV cycles of setup and hold
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    bit_next   = bit_cnt;
    div_next   = div_cnt;
    ser_next   = ser_out;
    case (state)
      IDLE: begin
        div_next = 8'd0;
        if (start) begin
          shreg_next = data_in;
          bit_next   = '0;
          ser_next   = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
          state_next = CLK_LO;
        end
      end
      CLK_LO: begin
        if (div_done) begin
          div_next   = 8'd0;
          state_next = CLK_HI;
        end else begin
          div_next = div_cnt + 8'd1;
        end
      end
      CLK_HI: begin
        if (div_done) begin
          div_next = 8'd0;
          if (bit_cnt == BIT_LAST) begin
            state_next = LATCH;
          end else begin
            bit_next   = bit_cnt + BW'(1);
            shreg_next = shifted;
            ser_next   = MSB_FIRST ? shifted[WIDTH-1] : shifted[0];
            state_next = CLK_LO;
          end
        end else begin
          div_next = div_cnt + 8'd1;
        end
      end
      LATCH: begin
        if (div_done) begin
          div_next   = 8'd0;
          ser_next   = 1'b0;
          state_next = IDLE;
        end else begin
          div_next = div_cnt + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Pin outputs are registered from the next state so the external chain never sees decode glitches
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= 8'd0;
      ser_out  <= 1'b0;
      sr_clk   <= 1'b0;
      sr_latch <= 1'b0;
      busy     <= 1'b0;
    end else begin
      shreg    <= shreg_next;
      bit_cnt  <= bit_next;
      div_cnt  <= div_next;
      ser_out  <= ser_next;
      sr_clk   <= (state_next == CLK_HI);
      sr_latch <= (state_next == LATCH);
      busy     <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_pwm_serial_driver.sv
// Bench for pwm_serial_driver: default instance plus an LSB-first CLK_DIV=1 instance,
// each observed through a behavioural model of an external 74HC595 chain.
module tb_pwm_serial_driver;

`ifdef PWM_SERIAL_SKIP_UNCHANGED_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] a_data_in, b_data_in;
  logic       a_valid, a_ready, a_ser, a_sr_clk, a_latch, a_busy;
  logic       b_valid, b_ready, b_ser, b_sr_clk, b_latch, b_busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  pwm_serial_driver dut_a (
    .clock(clock), .reset(reset), .data_in(a_data_in), .data_valid(a_valid),
    .data_ready(a_ready), .ser_out(a_ser), .sr_clk(a_sr_clk), .sr_latch(a_latch), .busy(a_busy)
  );

  pwm_serial_driver #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut_b (
    .clock(clock), .reset(reset), .data_in(b_data_in), .data_valid(b_valid),
    .data_ready(b_ready), .ser_out(b_ser), .sr_clk(b_sr_clk), .sr_latch(b_latch), .busy(b_busy)
  );

  // external shift/storage register models
  logic [7:0] a_chain = 8'h00, a_latched = 8'h00, b_chain = 8'h00, b_latched = 8'h00;
  int         a_rises = 0, a_latches = 0, b_rises = 0, b_latches = 0;
  logic       a_bits[$];
  logic       b_bits[$];
  logic [7:0] a_hist[$];

  always @(posedge a_sr_clk) begin
    a_chain = {a_chain[6:0], a_ser};
    a_rises++;
    a_bits.push_back(a_ser);
  end
  always @(posedge a_latch) begin
    a_latched = a_chain;
    a_latches++;
    a_hist.push_back(a_chain);
  end
  always @(posedge b_sr_clk) begin
    b_chain = {b_chain[6:0], b_ser};
    b_rises++;
    b_bits.push_back(b_ser);
  end
  always @(posedge b_latch) begin
    b_latched = b_chain;
    b_latches++;
  end

  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_latched;
    int         exp_busy;
    int         exp_width;
  } vec_t;

  vec_t table_a[4];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? a_ready : b_ready;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? a_busy : b_busy;
  endfunction
  function automatic logic get_latch(input int sel);
    return (sel == 0) ? a_latch : b_latch;
  endfunction

  function automatic logic [7:0] reverse8(input logic [7:0] w);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = w[7-k];
    return r;
  endfunction

  task automatic drive(input int sel, input logic [7:0] w, input logic v);
    if (sel == 0) begin
      a_data_in = w;
      a_valid   = v;
    end else begin
      b_data_in = w;
      b_valid   = v;
    end
  endtask

  // offer one word, wait for the handshake, then time the busy window and the latch pulse
  task automatic applyStimulus(input int sel, input logic [7:0] word,
                               output int busy_cycles, output int latch_cycles, output int wait_cycles);
    @(negedge clock);
    drive(sel, word, 1'b1);
    wait_cycles = 0;
    while (!get_ready(sel) && wait_cycles < 100) begin
      @(negedge clock);
      wait_cycles++;
    end
    if (wait_cycles >= 100) checkOutput("accept_timeout", 32'd1, 32'd0);
    @(negedge clock);
    drive(sel, word, 1'b0);
    busy_cycles  = 0;
    latch_cycles = 0;
    while (get_busy(sel) && busy_cycles < 1000) begin
      if (get_latch(sel)) latch_cycles++;
      busy_cycles++;
      @(negedge clock);
    end
    if (busy_cycles >= 1000) checkOutput("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic pulseReset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int         busy_c, lw, wc, r0, l0, first, second;
    logic [7:0] word, prev_word, model_latched, model_last;
    logic [7:0] exp_bits;
    logic       skip;

    // reset held with a valid word offered
    reset     = 1'b0;
    a_valid   = 1'b1;
    a_data_in = 8'hA5;
    b_valid   = 1'b1;
    b_data_in = 8'hA5;
    repeat (3) begin
      @(negedge clock);
      checkOutput("rst_ser", a_ser, 0);
      checkOutput("rst_sr_clk", a_sr_clk, 0);
      checkOutput("rst_sr_latch", a_latch, 0);
      checkOutput("rst_busy", a_busy, 0);
      checkOutput("rst_ready", a_ready, 1);
      checkOutput("rst_b_busy", b_busy, 0);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    reset   = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("rst_no_capture_busy", a_busy, 0);
    checkOutput("rst_no_capture_rises", a_rises, 0);
    checkOutput("rst_no_capture_latches", a_latches, 0);

    // table-driven single words on the default instance
    table_a[0] = '{8'hA5, 8'hA5, 34, 2};
    table_a[1] = '{8'h01, 8'h01, 34, 2};
    table_a[2] = '{8'h80, 8'h80, 34, 2};
    table_a[3] = '{8'hC3, 8'hC3, 34, 2};
    exp_bits = 8'b1010_0101;
    for (int i = 0; i < 4; i++) begin
      r0 = a_rises;
      l0 = a_latches;
      a_bits.delete();
      applyStimulus(0, table_a[i].word, busy_c, lw, wc);
      checkOutput("tbl_busy", busy_c, table_a[i].exp_busy);
      checkOutput("tbl_latch_width", lw, table_a[i].exp_width);
      checkOutput("tbl_rises", a_rises - r0, 8);
      checkOutput("tbl_latches", a_latches - l0, 1);
      checkOutput("tbl_latched", a_latched, table_a[i].exp_latched);
      checkOutput("tbl_ser_idle", a_ser, 0);
      checkOutput("tbl_ready_idle", a_ready, 1);
      if (i == 0) begin
        checkOutput("a5_bit_count", a_bits.size(), 8);
        for (int k = 0; k < 8 && k < a_bits.size(); k++)
          checkOutput("a5_bit", a_bits[k], exp_bits[7-k]);
      end
    end

    // randomized words against the chain model, with deliberate repeats
    model_latched = 8'hC3;
    model_last    = 8'hC3;
    prev_word     = 8'hC3;
    for (int i = 0; i < 16; i++) begin
      word = (i % 4 == 3) ? prev_word : 8'($urandom_range(0, 255));
      skip = SKIP_EN && (word == model_last);
      r0 = a_rises;
      l0 = a_latches;
      applyStimulus(0, word, busy_c, lw, wc);
      if (!skip) model_latched = word;
      model_last = word;
      prev_word  = word;
      checkOutput("rnd_busy", busy_c, skip ? 0 : (2 * 8 + 1) * 2);
      checkOutput("rnd_rises", a_rises - r0, skip ? 0 : 8);
      checkOutput("rnd_latches", a_latches - l0, skip ? 0 : 1);
      checkOutput("rnd_latched", a_latched, model_latched);
    end

    // LSB-first, CLK_DIV=1 instance
    b_bits.delete();
    r0 = b_rises;
    applyStimulus(1, 8'h01, busy_c, lw, wc);
    checkOutput("lsb_busy", busy_c, 17);
    checkOutput("lsb_latch_width", lw, 1);
    checkOutput("lsb_rises", b_rises - r0, 8);
    checkOutput("lsb_bit_count", b_bits.size(), 8);
    for (int k = 0; k < 8 && k < b_bits.size(); k++)
      checkOutput("lsb_bit", b_bits[k], (k == 0) ? 1 : 0);
    checkOutput("lsb_latched", b_latched, 8'h80);
    model_last = 8'h01;
    for (int i = 0; i < 6; i++) begin
      word = 8'($urandom_range(0, 255));
      skip = SKIP_EN && (word == model_last);
      r0 = b_rises;
      l0 = b_latched;
      applyStimulus(1, word, busy_c, lw, wc);
      model_last = word;
      checkOutput("lsb_rnd_busy", busy_c, skip ? 0 : 17);
      checkOutput("lsb_rnd_latched", b_latched, skip ? 8'(l0) : reverse8(word));
    end

    // back-to-back with data_valid held: second word waits for the first IDLE cycle
    pulseReset();
    a_hist.delete();
    @(negedge clock);
    a_data_in = 8'hFF;
    a_valid   = 1'b1;
    first     = -1;
    second    = -1;
    for (int c = 0; c < 200 && second < 0; c++) begin
      if (a_ready) begin
        if (first < 0) first = c;
        else second = c;
      end
      @(negedge clock);
      if (first >= 0) a_data_in = 8'h00;
    end
    a_valid = 1'b0;
    checkOutput("b2b_second_accepted", (second >= 0) ? 1 : 0, 1);
    checkOutput("b2b_spacing", second - first, 35);
    for (int g = 0; g < 100 && a_busy; g++) @(negedge clock);
    checkOutput("b2b_done", a_busy, 0);
    checkOutput("b2b_latch_count", a_hist.size(), 2);
    if (a_hist.size() >= 2) begin
      checkOutput("b2b_first_word", a_hist[0], 8'hFF);
      checkOutput("b2b_second_word", a_hist[1], 8'h00);
    end

    // reset after the third sr_clk rise
    r0 = a_rises;
    l0 = a_latches;
    @(negedge clock);
    a_data_in = 8'hB6;
    a_valid   = 1'b1;
    @(negedge clock);
    a_valid = 1'b0;
    for (int g = 0; g < 200 && (a_rises - r0) < 3; g++) @(negedge clock);
    checkOutput("mid_three_rises", a_rises - r0, 3);
    checkOutput("mid_busy_before", a_busy, 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("mid_ser", a_ser, 0);
    checkOutput("mid_sr_clk", a_sr_clk, 0);
    checkOutput("mid_sr_latch", a_latch, 0);
    checkOutput("mid_busy", a_busy, 0);
    checkOutput("mid_ready", a_ready, 1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("mid_no_latch", a_latches - l0, 0);
    r0 = a_rises;
    applyStimulus(0, 8'h5A, busy_c, lw, wc);
    checkOutput("mid_after_busy", busy_c, 34);
    checkOutput("mid_after_rises", a_rises - r0, 8);
    checkOutput("mid_after_latched", a_latched, 8'h5A);

    // same word twice
    pulseReset();
    r0 = a_rises;
    applyStimulus(0, 8'h3C, busy_c, lw, wc);
    checkOutput("dup1_busy", busy_c, 34);
    checkOutput("dup1_rises", a_rises - r0, 8);
    checkOutput("dup1_latched", a_latched, 8'h3C);
    r0 = a_rises;
    l0 = a_latches;
    applyStimulus(0, 8'h3C, busy_c, lw, wc);
    checkOutput("dup2_wait", wc, 0);
    checkOutput("dup2_busy", busy_c, SKIP_EN ? 0 : 34);
    checkOutput("dup2_rises", a_rises - r0, SKIP_EN ? 0 : 8);
    checkOutput("dup2_latches", a_latches - l0, SKIP_EN ? 0 : 1);
    checkOutput("dup2_ready", a_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pwm_serial_driver.md
Name: pwm_serial_driver

Overview:
- Downstream stage of the PWM shift-register generator.
- Takes each latched parallel PWM word and serialises it onto an external 74HC595-style chain through three pins: SER, SRCLK and RCLK.
- This lets the PWM pattern drive off-chip LED/driver registers.
- A valid/ready handshake on the parallel side makes the block stall-safe when the generator updates faster than the serial link can ship words.

Parameters:
- WIDTH, 8: bits per word; also the number of external shift-register stages.
- CLK_DIV, 2: system clocks per half-period of sr_clk; legal values 1 to 255.
- MSB_FIRST, 1: 1 shifts data_in[WIDTH-1] first; 0 shifts data_in[0] first.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (active when 0).
- data_in  in  WIDTH  parallel PWM word to ship.
- data_valid  in  1  data_in is valid.
- data_ready  out  1  block can accept a word this cycle.
- ser_out  out  1  serial data to the external SER pin.
- sr_clk  out  1  external shift clock; external chip samples on its rising edge.
- sr_latch  out  1  external storage-register clock (RCLK); a high pulse commits the word.
- busy  out  1  a transfer is in progress.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE.
  - ser_out=0, sr_clk=0, sr_latch=0, busy=0, data_ready=1.
  - Shift register, div_cnt and bit_cnt all cleared.
- State machine: IDLE -> CLK_LO -> CLK_HI -> (CLK_LO again, or LATCH) -> IDLE.
- IDLE:
  - data_ready=1.
  - On data_valid&data_ready, capture data_in into an internal shift register, set bit_cnt=0 and go to CLK_LO.
  - ser_out is driven with the first bit in the same edge as the capture.
- CLK_LO:
  - sr_clk=0, ser_out holds the current bit, for exactly CLK_DIV cycles.
  - Then go to CLK_HI.
- CLK_HI:
  - sr_clk=1 for exactly CLK_DIV cycles.
  - On exit, if bit_cnt==WIDTH-1, go to LATCH.
  - Otherwise: increment bit_cnt, shift the internal register, present the next bit on ser_out, and go to CLK_LO.
  - ser_out changes only on the CLK_HI->CLK_LO edge, giving CLK_DIV cycles of setup and hold around each sr_clk rise.
- LATCH:
  - sr_clk=0, sr_latch=1 for exactly CLK_DIV cycles, then go to IDLE.
  - ser_out returns to 0 on entry to IDLE.
- busy=1 in every state except IDLE; data_ready equals !busy.
- Transfer timing:
  - Accept-to-IDLE = (2*WIDTH+1)*CLK_DIV cycles; defaults give 34.
  - A new word can be accepted on the first IDLE cycle, so back-to-back throughput is one word per 34+1 cycles.
- Exactly WIDTH rising edges of sr_clk per word, followed by exactly one sr_latch pulse.
- data_valid while busy: ignored (not captured); the upstream stage must hold data_valid until data_ready.
- data_in changing mid-transfer: no effect; the captured copy is used.
- Reset mid-transfer: all outputs go to reset values immediately; the external chain is left partially shifted and is not latched.
- bit_cnt width is $clog2(WIDTH); div_cnt width is 8 bits. Neither counter may wrap past its terminal value.

Optional Feature:
- Macro: PWM_SERIAL_SKIP_UNCHANGED_EN.
- When defined:
  - The block holds last_word, the most recently latched word; reset value 0.
  - A handshake whose data_in equals last_word completes in one cycle: data_ready stays 1, the state stays IDLE, and no sr_clk or sr_latch activity occurs.
  - A differing word transfers normally and updates last_word on entry to LATCH.
- When undefined: every accepted word is shifted and latched, even if it repeats.

Test Plan:
- Reset:
  - Stimulus: hold reset=0 for 3 cycles, with data_valid=1 and data_in=8'hA5.
  - Required: ser_out=0, sr_clk=0, sr_latch=0, busy=0, data_ready=1; no capture occurs.
- Single word, defaults:
  - Stimulus: data_in=8'hA5, one-cycle valid.
  - Required: 8 sr_clk rises; ser_out sampled at the rises = 1,0,1,0,0,1,0,1; one sr_latch pulse 2 cycles wide; busy high for 34 cycles, then data_ready=1.
- MSB_FIRST=0, CLK_DIV=1:
  - Stimulus: data_in=8'h01.
  - Required: sampled bits = 1,0,0,0,0,0,0,0; busy for 17 cycles.
- Back-to-back with stall:
  - Stimulus: hold data_valid=1, data_in=8'hFF, then 8'h00 offered while busy.
  - Required: the second word is accepted only on the first IDLE cycle; the external model shows FF latched, then 00.
- Reset mid-transfer:
  - Stimulus: assert reset after the 3rd sr_clk rise.
  - Required: outputs reset within the same cycle; no sr_latch pulse; the next word transfers correctly after release.
- PWM_SERIAL_SKIP_UNCHANGED_EN defined:
  - Stimulus: send 8'h3C twice.
  - Required: the first send is fully shifted; the second is accepted in 1 cycle with zero sr_clk edges.
  - Undefined-macro build: both sends are shifted.
